// File: rtl/gearbox_67_40.sv
// Transmit gearbox: packs 67-bit framed words into a continuous 40-bit lane.
// Optional header check enabled by GEARBOX_67_40_HDR_CHECK_EN.
module gearbox_67_40 (
  input  logic        clk,
  input  logic        arst,
  input  logic [66:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [39:0] dout,
  output logic        dout_valid,
  output logic        underflow,
  output logic        hdr_err
);

  logic [105:0] stor;
  logic [105:0] tmp;
  logic [6:0]   cnt;
  logic [6:0]   avail;
  logic         accept;
  logic         emit;

  assign din_ready = (cnt < 7'd40);
  assign accept    = din_valid & din_ready;
  assign emit      = (avail >= 7'd40);

  // New word lands directly below the bits already held.
  always_comb begin
    tmp   = stor;
    avail = cnt;
    if (accept) begin
      tmp   = stor | ({din, 39'b0} >> cnt);
      avail = cnt + 7'd67;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stor       <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      underflow <= din_ready & ~din_valid;
      if (emit) begin
        dout       <= tmp[105:66];
        dout_valid <= 1'b1;
        stor       <= tmp << 40;
        cnt        <= avail - 7'd40;
      end else begin
        dout       <= '0;
        dout_valid <= 1'b0;
        stor       <= tmp;
        cnt        <= avail;
      end
    end
  end

`ifdef GEARBOX_67_40_HDR_CHECK_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hdr_err <= 1'b0;
    end else begin
      hdr_err <= accept & ~^din[65:64];
    end
  end
`else
  assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_gearbox_67_40.sv
// Bench for gearbox_67_40: vector table plus bit-queue scoreboard.
// Header-error expectations follow GEARBOX_67_40_HDR_CHECK_EN.
module tb_gearbox_67_40;

  logic        clk;
  logic        arst;
  logic [66:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [39:0] dout;
  logic        dout_valid;
  logic        underflow;
  logic        hdr_err;

  gearbox_67_40 dut (
    .clk        (clk),
    .arst       (arst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .underflow  (underflow),
    .hdr_err    (hdr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] dout;
    logic        dv;
    logic        uf;
    logic        he;
  } exp_t;

  typedef struct {
    logic [66:0] din;
    logic        valid;
    logic        rdy;
    logic        dv;
    logic [39:0] dout;
  } vec_t;

  int   nchk;
  int   npass;
  bit   mq[$];
  exp_t sbq[$];
  logic last_acc;

  task automatic chk(input string name,
                     input logic [66:0] act,
                     input logic [66:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic [66:0] d, input logic v);
    exp_t e;
    logic rdy_m;
    din       = d;
    din_valid = v;
    rdy_m     = (mq.size() < 40);
    chk("din_ready", {66'b0, din_ready}, {66'b0, rdy_m});
    last_acc = v & rdy_m;
    if (last_acc)
      for (int i = 66; i >= 0; i--) mq.push_back(d[i]);
    e = '0;
    if (mq.size() >= 40) begin
      e.dv = 1'b1;
      for (int i = 39; i >= 0; i--) e.dout[i] = mq.pop_front();
    end
    e.uf = rdy_m & ~v;
`ifdef GEARBOX_67_40_HDR_CHECK_EN
    e.he = last_acc & (d[65:64] == 2'b00 || d[65:64] == 2'b11);
`else
    e.he = 1'b0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      nchk++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk("dout", {27'b0, dout}, {27'b0, e.dout});
      chk("dout_valid", {66'b0, dout_valid}, {66'b0, e.dv});
      chk("underflow", {66'b0, underflow}, {66'b0, e.uf});
      chk("hdr_err", {66'b0, hdr_err}, {66'b0, e.he});
    end
  endtask

  task automatic do_reset();
    #2;
    arst      = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("rst_dout", {27'b0, dout}, 67'd0);
    chk("rst_dv", {66'b0, dout_valid}, 67'd0);
    chk("rst_uf", {66'b0, underflow}, 67'd0);
    chk("rst_he", {66'b0, hdr_err}, 67'd0);
    chk("rst_ready", {66'b0, din_ready}, 67'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
    mq.delete();
    sbq.delete();
  endtask

  function automatic logic [66:0] rand_word();
    logic [95:0] r;
    logic [66:0] w;
    r = {$urandom(), $urandom(), $urandom()};
    w = r[66:0];
    w[65:64] = r[95] ? 2'b01 : 2'b10;
    return w;
  endfunction

  task automatic send(input logic [66:0] w);
    for (int t = 0; t < 4; t++) begin
      step(w, 1'b1);
      if (last_acc) return;
    end
    nchk++;
    $display("FAIL send_timeout: got no accept expected accept within 4");
  endtask

  initial begin
    vec_t tv[6];
    logic rp[6];
    int   acc;
    int   gaps;
    logic [66:0] w;
    logic [1:0]  h;

    nchk      = 0;
    npass     = 0;
    arst      = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    last_acc  = 1'b0;

    tv[0] = '{67'h1_0000_0000_0000_0001, 1'b1, 1'b1, 1'b1, 40'h20_0000_0000};
    tv[1] = '{67'h7_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 40'h00_0000_3FFF};
    tv[2] = '{67'h5_5555_5555_5555_5555, 1'b1, 1'b0, 1'b1, 40'hFF_FFFF_FFFF};
    tv[3] = '{67'h2_0000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 40'hFF_FD00_0000};
    tv[4] = '{67'h0,                     1'b0, 1'b0, 1'b1, 40'h00_0000_0000};
    tv[5] = '{67'h0,                     1'b0, 1'b1, 1'b0, 40'h00_0000_0000};
    rp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk("tbl_ready", {66'b0, din_ready}, {66'b0, tv[i].rdy});
      step(tv[i].din, tv[i].valid);
      chk("tbl_dv", {66'b0, dout_valid}, {66'b0, tv[i].dv});
      chk("tbl_dout", {27'b0, dout}, {27'b0, tv[i].dout});
    end

    // Continuous source: 67 cycles take 40 words with no gaps.
    do_reset();
    acc  = 0;
    gaps = 0;
    for (int i = 0; i < 67; i++) begin
      if (i < 6) chk("ready_pat", {66'b0, din_ready}, {66'b0, rp[i]});
      step(rand_word(), 1'b1);
      if (last_acc) acc++;
      if (!dout_valid) gaps++;
    end
    chk("steady_accepts", 67'(acc), 67'd40);
    chk("steady_gaps", 67'(gaps), 67'd0);
    chk("steady_wrap_ready", {66'b0, din_ready}, 67'd1);

    for (int t = 0; t < 4 && !din_ready; t++) step(rand_word(), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(rand_word(), 1'b0);
      chk("uf_pulse", {66'b0, underflow}, 67'd1);
      chk("uf_dv", {66'b0, dout_valid}, 67'd0);
      chk("uf_dout", {27'b0, dout}, 67'd0);
    end
    for (int i = 0; i < 20; i++) step(rand_word(), 1'b1);

    // Changing din every cycle, ready or not.
    for (int i = 0; i < 60; i++) step(rand_word(), 1'b1);
    for (int i = 0; i < 30; i++) step(rand_word(), ($urandom % 4) != 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      h = 2'(i);
      w = rand_word();
      w[65:64] = h;
      send(w);
`ifdef GEARBOX_67_40_HDR_CHECK_EN
      chk("hdr_case", {66'b0, hdr_err}, {66'b0, (h == 2'b00 || h == 2'b11)});
`else
      chk("hdr_case", {66'b0, hdr_err}, 67'd0);
`endif
    end

    // Reset with 54 bits held; next word must start at dout[39].
    do_reset();
    step(rand_word(), 1'b1);
    step(rand_word(), 1'b1);
    chk("pre_rst_ready", {66'b0, din_ready}, 67'd0);
    do_reset();
    w = rand_word();
    step(w, 1'b1);
    chk("post_rst_dout", {27'b0, dout}, {27'b0, w[66:27]});
    for (int i = 0; i < 10; i++) step(rand_word(), 1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
